// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter in front of a synchronous-read data RAM (1-cycle read latency).
// Round-robin on ties, optional bus lock for back-to-back transfers with a forced release.
module dmem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  output logic [DATA_W-1:0] m0_din,
  output logic              m0_grant,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic [DATA_W-1:0] m1_din,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din
);

  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             owner, owner_n;          // 0 = M0, 1 = M1
  logic             last_owner, last_owner_n;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_n;

  logic              m0_req, m1_req;
  logic              own_req, own_lock, own_wr, own_rd;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_dout;

  // Current owner's request, with write taking priority over read
  always_comb begin
    m0_req   = m0_rd | m0_wr;
    m1_req   = m1_rd | m1_wr;
    own_req  = owner ? m1_req  : m0_req;
    own_lock = owner ? m1_lock : m0_lock;
    own_wr   = owner ? m1_wr   : m0_wr;
    own_rd   = (owner ? m1_rd : m0_rd) & ~own_wr;
    own_addr = owner ? m1_addr : m0_addr;
    own_dout = owner ? m1_dout : m0_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lock_cnt   <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      lock_cnt   <= lock_cnt_n;
    end
  end

  // Arbitration and lock chaining
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    lock_cnt_n   = lock_cnt;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_n    = ADDR;
          lock_cnt_n = '0;
          if (m0_req && m1_req) begin
            owner_n = ~last_owner;
          end else begin
            owner_n = m1_req;
          end
        end
      end
      ADDR: begin
        state_n = DATA;
      end
      DATA: begin
        if (own_lock && own_req && (lock_cnt < LOCK_LAST)) begin
          state_n    = ADDR;
          lock_cnt_n = lock_cnt + CNT_W'(1);
        end else begin
          state_n      = IDLE;
          last_owner_n = owner;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Bus and grant decode; ADDR passes the owner's live inputs straight to the RAM
  always_comb begin
    mem_addr = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    mem_rd   = 1'b0;
    m0_grant = 1'b0;
    m1_grant = 1'b0;
    m0_din   = '0;
    m1_din   = '0;
    case (state)
      ADDR: begin
        mem_addr = own_addr;
        mem_dout = own_dout;
        mem_wr   = own_wr;
        mem_rd   = own_rd;
      end
      DATA: begin
        if (owner) begin
          m1_grant = 1'b1;
          m1_din   = mem_din;
        end else begin
          m0_grant = 1'b1;
          m0_din   = mem_din;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: directed arbitration scenarios plus two
// randomized masters checked against a shadow memory and grant-order log.
`timescale 1ns/1ps
module tb_dmem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_rd, m0_wr, m0_lock, m0_grant;
  logic [7:0] m0_addr, m0_dout, m0_din;
  logic       m1_rd, m1_wr, m1_lock, m1_grant;
  logic [7:0] m1_addr, m1_dout, m1_din;
  logic [7:0] mem_addr, mem_dout, mem_din;
  logic       mem_wr, mem_rd;

  dmem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_dout(m0_dout), .m0_din(m0_din), .m0_grant(m0_grant),
    .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_dout(m1_dout), .m1_din(m1_din), .m1_grant(m1_grant),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM with a bench-side preload port
  logic [7:0] ram [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wr) ram[mem_addr] <= mem_dout;
    if (mem_rd) mem_din <= ram[mem_addr];
  end

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q0[$], exp_q1[$];
  logic [7:0] shadow [256];
  int         glog_m[$], glog_c[$];
  int         n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input int m);
    exp_t       e;
    logic [7:0] din;
    int         qs;
    glog_m.push_back(m);
    glog_c.push_back(cyc);
    din = (m == 0) ? m0_din : m1_din;
    qs  = (m == 0) ? exp_q0.size() : exp_q1.size();
    chk($sformatf("m%0d_grant_expected", m), 32'(qs > 0), 32'(1));
    if (qs == 0) return;
    if (m == 0) e = exp_q0.pop_front();
    else e = exp_q1.pop_front();
    if (e.rd) chk($sformatf("m%0d_rd_data", m), 32'(din), 32'(e.data));
    else chk($sformatf("m%0d_wr_commit", m), 32'(ram[e.addr]), 32'(e.data));
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each grant
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("one_grant", 32'(m0_grant & m1_grant), 32'(0));
      chk("one_strobe", 32'(mem_wr & mem_rd), 32'(0));
      if (m0_grant !== 1'b1) chk("m0_din_quiet", 32'(m0_din), 32'(0));
      if (m1_grant !== 1'b1) chk("m1_din_quiet", 32'(m1_din), 32'(0));
      if (m0_grant === 1'b1) pop_chk(0);
      if (m1_grant === 1'b1) pop_chk(1);
    end
  end

  task automatic drive(input int m, input bit rd, input bit wr, input bit lock,
                       input logic [7:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_rd = rd; m0_wr = wr; m0_lock = lock; m0_addr = a; m0_dout = d;
    end else begin
      m1_rd = rd; m1_wr = wr; m1_lock = lock; m1_addr = a; m1_dout = d;
    end
  endtask

  task automatic idle(input int m);
    drive(m, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Issue one transfer, queue its expected result, hold until granted
  task automatic xfer(input int m, input bit rd, input bit wr, input bit lock,
                      input logic [7:0] a, input logic [7:0] d, output int gc);
    exp_t e;
    drive(m, rd, wr, lock, a, d);
    e.rd   = !wr;
    e.addr = a;
    if (wr) begin
      shadow[a] = d;
      e.data    = d;
    end else begin
      e.data = shadow[a];
    end
    if (m == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    gc = -1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (((m == 0) ? m0_grant : m1_grant) === 1'b1) begin
        gc = cyc;
        break;
      end
    end
    chk($sformatf("m%0d_grant_in_time", m), 32'(gc >= 0), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string name, input int em[$], input int ec[$], input int base);
    chk({name, "_count"}, 32'(glog_m.size()), 32'(em.size()));
    for (int i = 0; i < em.size() && i < glog_m.size(); i++) begin
      chk($sformatf("%s_who%0d", name, i), 32'(glog_m[i]), 32'(em[i]));
      chk($sformatf("%s_cyc%0d", name, i), 32'(glog_c[i] - base), 32'(ec[i]));
    end
  endtask

  task automatic rand_master(input int m, input int n);
    bit lock_prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      int         op, gap, g;
      bit         rd, wr, lock;
      logic [7:0] a, d;
      if (!lock_prev) begin
        idle(m);
        gap = $urandom_range(0, 3);
        for (int j = 0; j < gap; j++) begin
          @(posedge clk); #1;
        end
      end
      op   = $urandom_range(0, 3);
      rd   = (op != 1);
      wr   = (op == 1) || (op == 2);
      lock = ($urandom_range(0, 2) == 0) && (k < n - 1);
      a    = {1'(m), 7'($urandom)};
      d    = 8'($urandom);
      xfer(m, rd, wr, lock, a, d, g);
      lock_prev = lock;
    end
    idle(m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, g0, g1;
    int em[$], ec[$];
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    drive(0, 1'b1, 1'b0, 1'b1, 8'h33, 8'h44);
    drive(1, 1'b0, 1'b1, 1'b0, 8'hC5, 8'h5A);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = 8'(i); pre_data = 8'($urandom);
      shadow[i] = pre_data;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    // Reset holds everything quiet even with requests present
    @(negedge clk);
    chk("rst_m0_grant", 32'(m0_grant), 32'(0));
    chk("rst_m1_grant", 32'(m1_grant), 32'(0));
    chk("rst_mem_wr", 32'(mem_wr), 32'(0));
    chk("rst_mem_rd", 32'(mem_rd), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_dout", 32'(mem_dout), 32'(0));
    chk("rst_m0_din", 32'(m0_din), 32'(0));
    chk("rst_m1_din", 32'(m1_din), 32'(0));
    @(posedge clk); #1;
    idle(0); idle(1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: lone M0 write
    c = cyc;
    fork
      xfer(0, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h15, g0);
      begin
        repeat (2) @(negedge clk);
        chk("t1_mem_wr", 32'(mem_wr), 32'(1));
        chk("t1_mem_rd", 32'(mem_rd), 32'(0));
        chk("t1_mem_addr", 32'(mem_addr), 32'(8'h7F));
        chk("t1_mem_dout", 32'(mem_dout), 32'(8'h15));
      end
    join
    idle(0);
    chk("t1_latency", 32'(g0 - c), 32'(2));
    @(negedge clk);
    chk("t1_idle_wr", 32'(mem_wr), 32'(0));
    chk("t1_idle_grant", 32'(m0_grant), 32'(0));
    @(posedge clk); #1;

    // 2: M1 read of a preloaded location
    pre_we = 1'b1; pre_addr = 8'h40; pre_data = 8'hA5; shadow[8'h40] = 8'hA5;
    @(posedge clk); #1;
    pre_we = 1'b0;
    c = cyc;
    fork
      xfer(1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00, g1);
      begin
        repeat (2) @(negedge clk);
        chk("t2_mem_rd", 32'(mem_rd), 32'(1));
        chk("t2_mem_addr", 32'(mem_addr), 32'(8'h40));
        @(negedge clk);
        chk("t2_m1_grant", 32'(m1_grant), 32'(1));
        chk("t2_m1_din", 32'(m1_din), 32'(8'hA5));
        chk("t2_m0_din", 32'(m0_din), 32'(0));
      end
    join
    idle(1);
    chk("t2_latency", 32'(g1 - c), 32'(2));

    // 3a: tie from reset, M0 re-requests immediately -> M0, M1, M0
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    glog_m.delete(); glog_c.delete();
    c = cyc;
    fork
      begin
        xfer(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, g0);
        xfer(0, 1'b0, 1'b1, 1'b0, 8'h11, 8'(c), g0);
        idle(0);
      end
      begin xfer(1, 1'b1, 1'b0, 1'b0, 8'h90, 8'h00, g1); idle(1); end
    join
    em = {0, 1, 0}; ec = {2, 5, 8};
    chk_log("t3a", em, ec, c);
    // 3b: fresh tie after M0 was served last -> M1 first
    glog_m.delete(); glog_c.delete();
    c = cyc;
    fork
      begin xfer(0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00, g0); idle(0); end
      begin xfer(1, 1'b0, 1'b1, 1'b0, 8'h91, 8'h6C, g1); idle(1); end
    join
    em = {1, 0}; ec = {2, 5};
    chk_log("t3b", em, ec, c);

    // 4: locked two-byte stack frame while M1 waits
    glog_m.delete(); glog_c.delete();
    c = cyc;
    fork
      begin
        xfer(0, 1'b0, 1'b1, 1'b1, 8'h7F, 8'h03, g0);
        xfer(0, 1'b0, 1'b1, 1'b0, 8'h7E, 8'h22, g0);
        idle(0);
      end
      begin @(posedge clk); #1; xfer(1, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h00, g1); idle(1); end
    join
    em = {0, 0, 1}; ec = {2, 4, 7};
    chk_log("t4", em, ec, c);

    // 5: six locked M0 transfers, forced release lets M1 in after the fourth
    glog_m.delete(); glog_c.delete();
    c = cyc;
    fork
      begin
        for (int k = 0; k < 6; k++)
          xfer(0, 1'b0, 1'b1, k < 5, 8'(8'h70 - k), 8'($urandom), g0);
        idle(0);
      end
      begin @(posedge clk); #1; xfer(1, 1'b1, 1'b0, 1'b0, 8'hB3, 8'h00, g1); idle(1); end
    join
    em = {0, 0, 0, 0, 1, 0, 0}; ec = {2, 4, 6, 8, 11, 14, 16};
    chk_log("t5", em, ec, c);

    // 6: reset during the ADDR cycle of an M1 read
    glog_m.delete(); glog_c.delete();
    drive(1, 1'b1, 1'b0, 1'b0, 8'hB0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_addr_strobe", 32'(mem_rd), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    chk("t6_no_m1_grant", 32'(m1_grant), 32'(0));
    chk("t6_rd_off", 32'(mem_rd), 32'(0));
    chk("t6_wr_off", 32'(mem_wr), 32'(0));
    @(posedge clk); #1;
    c = cyc;
    xfer(0, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00, g0);
    idle(0);
    em = {0}; ec = {2};
    chk_log("t6", em, ec, c);

    // Randomized concurrent masters on disjoint address halves
    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", 32'(exp_q0.size()), 32'(0));
    chk("q1_drained", 32'(exp_q1.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
